spad_stream_reader: RTL and testbench
=====================================

// Module: spad_stream_reader
// PURPOSE
//  Drains a contiguous address range of the scratchpad (one-write/one-read, combinational read port)
//  into a valid/ready output stream for the downstream compute datapath. A single command supplies
//  base address and beat count; the block walks the range, registers each word and tags the final beat.
//  Sits directly downstream of the scratchpad read port; sustains 1 beat/cycle under continuous out_ready.
// PARAMETERS
//  ADDR_WIDTH  8   scratchpad address width; depth = 2^ADDR_WIDTH
//  DATA_WIDTH  32  word width, equal to scratchpad DATA_WIDTH
//  LEN_WIDTH   ADDR_WIDTH+1  command length width (allows a full-depth transfer)
// PORTS
//  clk        in   1           single clock, all state on posedge
//  rst_n      in   1           asynchronous active-low reset
//  cmd_valid  in   1           command offered
//  cmd_ready  out  1           block idle and able to accept a command
//  cmd_base   in   ADDR_WIDTH  first scratchpad address
//  cmd_len    in   LEN_WIDTH   number of words to stream (0 legal)
//  spad_raddr out  ADDR_WIDTH  scratchpad read address
//  spad_rdata in   DATA_WIDTH  scratchpad read data (same-cycle as spad_raddr)
//  out_valid  out  1           output beat valid
//  out_ready  in   1           downstream accepts beat
//  out_data   out  DATA_WIDTH  output word
//  out_last   out  1           marks final beat of the command
//  busy       out  1           command in progress
//  done       out  1           one-cycle pulse: command complete
// BEHAVIOUR
//  Reset (rst_n low, async): state=IDLE; out_valid=0, out_data=0, out_last=0, busy=0, done=0,
//   spad_raddr=0, internal base/len/issue counters=0. cmd_ready=1 after reset release.
//  States: IDLE, RUN.
//  IDLE: cmd_ready=1. Handshake cmd_valid&&cmd_ready:
//   - cmd_len!=0: latch base/len, issue count=0, spad_raddr<=cmd_base, go RUN, busy=1 next cycle.
//   - cmd_len==0: stay IDLE, done=1 next cycle, no beats emitted.
//  RUN: cmd_ready=0; cmd_valid ignored (no queuing).
//   - spad_raddr is registered = base + issued, truncated to ADDR_WIDTH (wraps past 2^ADDR_WIDTH-1 to 0).
//   - load = (issued < len) && (!out_valid || out_ready). On load: out_data<=spad_rdata, out_valid<=1,
//     out_last<=(issued==len-1), issued++, spad_raddr++ (wrapping).
//   - out_valid&&out_ready&&!load: out_valid<=0, out_last<=0.
//   - out_valid/out_data/out_last held stable while out_valid&&!out_ready (AXI-style, no drop).
//   - Final handshake (out_valid&&out_ready&&out_last): next cycle state=IDLE, busy=0, out_valid=0,
//     done=1 for exactly one cycle; cmd_ready=1 in that same cycle.
//  Latency: cmd accepted cycle T -> out_valid first high T+2 (raddr registered T+1, data registered T+2).
//  Throughput: with out_ready held high, beats on consecutive cycles; N-word command occupies
//   RUN for N+1 cycles, done at T+N+2.
//  Backpressure: out_ready low freezes issue; no address advance, no lost or duplicated words.
//  Scratchpad writes to a not-yet-read address during RUN are visible (read is live, not snapshotted).
//  Reset mid-RUN: transfer aborted immediately, no done pulse, outputs to reset values.
//  issued/len compare uses LEN_WIDTH arithmetic; no overflow for len up to 2^ADDR_WIDTH.
// TESTING
//  1) Preload spad[i]=0x100+i; cmd base=4,len=4, out_ready=1 -> beats 0x104..0x107 on 4 consecutive
//     cycles starting T+2, out_last only on 0x107, done pulse T+6, cmd_ready back high with done.
//  2) Same cmd, out_ready toggled 1,0,0,1,0,1... -> identical 4-word sequence, out_data stable while stalled,
//     no duplicates, done one cycle after last accepted beat.
//  3) ADDR_WIDTH=8, base=0xFE, len=4 -> data from addresses 0xFE,0xFF,0x00,0x01 in order.
//  4) cmd_len=0 -> no out_valid, done pulse the following cycle, busy never asserted.
//  5) Full depth: base=0, len=256 -> 256 beats, last beat data=spad[255], out_last once, done once.
//  6) Assert rst_n low after 2 beats of a len=8 command -> out_valid/busy/done 0 immediately; new
//     cmd base=0,len=1 after release -> single beat spad[0] with out_last=1.

Source files
------------

// File: rtl/spad_stream_reader.sv
// Streams a contiguous scratchpad address range out on a valid/ready interface.
// One command (base, len) walks base..base+len-1 with address wrap. Each word is
// registered into out_data, and the final word is tagged with out_last.
// Ports:
//   clk, rst_n                  clock and async active-low reset
//   cmd_valid/cmd_ready         command handshake; cmd_base and cmd_len are the payload
//   spad_raddr/spad_rdata       scratchpad read port (combinational read)
//   out_valid/out_ready         output stream handshake; out_data and out_last are the payload
//   busy                        command in progress
//   done                        one-cycle completion pulse
module spad_stream_reader #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] spad_raddr,
  input  logic [DATA_WIDTH-1:0] spad_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] raddr_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_d, last_d, busy_d, done_d;
  logic                  load;

  // Ready is a pure decode of the state flop, so it is high in the same cycle as done.
  assign cmd_ready = (state_q == IDLE);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      spad_raddr <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      spad_raddr <= raddr_d;
      out_data   <= data_d;
      out_valid  <= valid_d;
      out_last   <= last_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    issued_d = issued_q;
    raddr_d  = spad_raddr;
    data_d   = out_data;
    valid_d  = out_valid;
    last_d   = out_last;
    done_d   = 1'b0;
    load     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len != '0) begin
            len_d    = cmd_len;
            issued_d = '0;
            raddr_d  = cmd_base;
            state_d  = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        // Refill the output register when it is empty or is being drained this cycle.
        load = (issued_q < len_q) && (!out_valid || out_ready);
        if (load) begin
          data_d   = spad_rdata;
          valid_d  = 1'b1;
          last_d   = (issued_q == len_q - LEN_WIDTH'(1));
          issued_d = issued_q + LEN_WIDTH'(1);
          raddr_d  = spad_raddr + ADDR_WIDTH'(1);
        end else if (out_valid && out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
        if (out_valid && out_ready && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

endmodule

// File: tb/tb_spad_stream_reader.sv
module tb_spad_stream_reader;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = AW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_base;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] spad_raddr;
  logic [DW-1:0] spad_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [256];
  assign spad_rdata = mem[spad_raddr];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spad_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .spad_raddr(spad_raddr), .spad_rdata(spad_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic [15:0]   rdy;        // out_ready pattern, bit (k-1)%16 driven in cycle k
    logic [DW-1:0] exp_first;
    logic [DW-1:0] exp_last;
    int            exp_done_k; // cycles after the command edge until done is seen
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int            beats;
    int            done_k;
    logic          r;
    logic          pv, pr;
    logic [DW-1:0] pd, first_d, last_d;
    beats = 0; done_k = -1; pv = 1'b0; pr = 1'b0; pd = '0; first_d = '0; last_d = '0;
    @(negedge clk);
    chk("cmd_ready_idle", DW'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_base = v.base; cmd_len = v.len;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy_after_cmd", DW'(busy), 1);
    chk("cmd_ready_run", DW'(cmd_ready), 0);
    for (int k = 1; k < 400; k++) begin
      @(negedge clk);
      if (done) begin
        done_k = k;
        break;
      end
      if (pv && !pr) begin
        chk("stall_valid_held", DW'(out_valid), 1);
        chk("stall_data_held", out_data, pd);
      end
      r = v.rdy[4'((k - 1) % 16)];
      out_ready = r;
      if (out_valid && r) begin
        chk("beat_data", out_data, 32'h100 + DW'(8'(v.base + 8'(beats))));
        chk("beat_last", DW'(out_last), DW'(beats == int'(v.len) - 1));
        if (beats == 0) first_d = out_data;
        last_d = out_data;
        beats++;
      end
      pv = out_valid; pr = r; pd = out_data;
    end
    if (done_k < 0) chk("done_timeout", 0, 1);
    chk("beat_count", DW'(beats), DW'(v.len));
    chk("first_word", first_d, v.exp_first);
    chk("last_word", last_d, v.exp_last);
    chk("done_cycle", DW'(done_k), DW'(v.exp_done_k));
    chk("done_busy", DW'(busy), 0);
    chk("done_valid", DW'(out_valid), 0);
    chk("done_cmd_ready", DW'(cmd_ready), 1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("done_single", DW'(done), 0);
  endtask

  initial begin
    vecs[0] = '{base: 8'h04, len: 9'd4,   rdy: 16'hFFFF, exp_first: 32'h104, exp_last: 32'h107, exp_done_k: 5};
    vecs[1] = '{base: 8'h04, len: 9'd4,   rdy: 16'hFFA9, exp_first: 32'h104, exp_last: 32'h107, exp_done_k: 9};
    vecs[2] = '{base: 8'hFE, len: 9'd4,   rdy: 16'hFFFF, exp_first: 32'h1FE, exp_last: 32'h101, exp_done_k: 5};
    vecs[3] = '{base: 8'h00, len: 9'd256, rdy: 16'hFFFF, exp_first: 32'h100, exp_last: 32'h1FF, exp_done_k: 257};

    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + DW'(i);
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", DW'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", DW'(out_last), 0);
    chk("rst_busy", DW'(busy), 0);
    chk("rst_done", DW'(done), 0);
    chk("rst_raddr", DW'(spad_raddr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst", DW'(cmd_ready), 1);

    for (int i = 0; i < 4; i++) run_cmd(vecs[i]);

    // Zero-length command: done the next cycle with no beats and no busy.
    cmd_valid = 1'b1; cmd_base = 8'h10; cmd_len = '0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("len0_done", DW'(done), 1);
    chk("len0_busy", DW'(busy), 0);
    chk("len0_valid", DW'(out_valid), 0);
    chk("len0_cmd_ready", DW'(cmd_ready), 1);
    @(negedge clk);
    chk("len0_done_single", DW'(done), 0);
    chk("len0_valid2", DW'(out_valid), 0);

    // Reset mid-transfer after two beats have been accepted.
    cmd_valid = 1'b1; cmd_base = 8'h00; cmd_len = 9'd8; out_ready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_beat0", out_data, 32'h100);
    @(negedge clk);
    chk("abort_beat1", out_data, 32'h101);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", DW'(out_valid), 0);
    chk("abort_busy", DW'(busy), 0);
    chk("abort_done", DW'(done), 0);
    chk("abort_raddr", DW'(spad_raddr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd('{base: 8'h00, len: 9'd1, rdy: 16'hFFFF, exp_first: 32'h100, exp_last: 32'h100, exp_done_k: 2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
